// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects operand A, operand B and opcode from a byte
// stream, presents them to the shared combinational ALU for one execute
// cycle, and returns the result byte on an output stream.
module alu_cmd_sequencer #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6,
    parameter int TIMEOUT   = 100000
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [NB_DATA-1:0]   o_alu_op_a,
    output logic [NB_DATA-1:0]   o_alu_op_b,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic                 o_err_opcode,
    output logic                 o_timeout
);

    localparam int NB_CNT = $clog2(TIMEOUT + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT - 1);

    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(32'h20);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(32'h22);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(32'h24);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(32'h25);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(32'h26);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(32'h27);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(32'h03);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(32'h02);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    state_t              state;
    logic [NB_CNT-1:0]   idle_cnt;
    logic [1:0]          rst_sync;
    logic                rst_int_n;
    logic                accept;
    logic                mid_command;
    logic                expire;
    logic                opcode_ok;
    logic [NB_OPCODE-1:0] opcode_low;

    // Reset asserts asynchronously and releases two edges after i_reset_n
    // rises, so the first edge the FSM sees out of reset is a clean one.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // Ready is a pure decode of the collecting states; EXEC/SEND stall upstream.
    assign o_rx_ready  = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_OP);
    assign accept      = o_rx_ready && i_rx_valid;
    assign mid_command = (state == WAIT_B) || (state == WAIT_OP);
    // A byte landing on the expiry edge wins over the timeout.
    assign expire      = mid_command && !accept && (idle_cnt == CNT_LAST);

    // Opcode byte is legal only with the bits above the opcode field clear
    // and the remaining field matching one of the supported ALU operations.
    assign opcode_low = i_rx_data[NB_OPCODE-1:0];

    always_comb begin
        opcode_ok = 1'b0;
        if ((i_rx_data >> NB_OPCODE) == '0) begin
            case (opcode_low)
                OP_ADD, OP_SUB, OP_AND, OP_OR,
                OP_XOR, OP_NOR, OP_SRA, OP_SRL: opcode_ok = 1'b1;
                default:                        opcode_ok = 1'b0;
            endcase
        end
    end

    // Inter-byte idle counter; only runs while a command is partially loaded.
    always_ff @(posedge i_clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idle_cnt <= '0;
        end else if (accept || !mid_command || expire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Command FSM with registered ALU operands, result and event pulses.
    always_ff @(posedge i_clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= WAIT_A;
            o_alu_op_a   <= '0;
            o_alu_op_b   <= '0;
            o_alu_opcode <= '0;
            o_tx_data    <= '0;
            o_tx_valid   <= 1'b0;
            o_err_opcode <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_err_opcode <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (accept) begin
                        o_alu_op_a <= i_rx_data;
                        state      <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (accept) begin
                        o_alu_op_b <= i_rx_data;
                        state      <= WAIT_OP;
                    end else if (expire) begin
                        o_timeout <= 1'b1;
                        state     <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (accept) begin
                        if (opcode_ok) begin
                            o_alu_opcode <= opcode_low;
                            state        <= EXEC;
                        end else begin
                            o_err_opcode <= 1'b1;
                            state        <= WAIT_A;
                        end
                    end else if (expire) begin
                        o_timeout <= 1'b1;
                        state     <= WAIT_A;
                    end
                end
                EXEC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        state      <= WAIT_A;
                    end
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    state      <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU attached.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       o_rx_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready = 1'b1;
    logic [7:0] o_alu_op_a;
    logic [7:0] o_alu_op_b;
    logic [5:0] o_alu_opcode;
    logic [7:0] i_alu_result;
    logic       o_err_opcode;
    logic       o_timeout;

    int tests_run = 0;
    int tests_failed = 0;

    alu_cmd_sequencer #(
        .NB_DATA   (8),
        .NB_OPCODE (6),
        .TIMEOUT   (16)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (i_reset_n),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_alu_op_a   (o_alu_op_a),
        .o_alu_op_b   (o_alu_op_b),
        .o_alu_opcode (o_alu_opcode),
        .i_alu_result (i_alu_result),
        .o_err_opcode (o_err_opcode),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared combinational ALU.
    always_comb begin
        case (o_alu_opcode)
            6'h20:   i_alu_result = o_alu_op_a + o_alu_op_b;
            6'h22:   i_alu_result = o_alu_op_a - o_alu_op_b;
            6'h24:   i_alu_result = o_alu_op_a & o_alu_op_b;
            6'h25:   i_alu_result = o_alu_op_a | o_alu_op_b;
            6'h26:   i_alu_result = o_alu_op_a ^ o_alu_op_b;
            6'h27:   i_alu_result = ~(o_alu_op_a | o_alu_op_b);
            6'h03:   i_alu_result = $signed(o_alu_op_a) >>> o_alu_op_b;
            6'h02:   i_alu_result = o_alu_op_a >> o_alu_op_b;
            default: i_alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends just after a falling edge; the byte is taken on the
    // first rising edge that sees o_rx_ready high.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait_expired", 32'(n >= 50), 32'd0);
        @(negedge clk);
        i_rx_valid = 1'b0;
        $display("[TB] byte 0x%02h sent", b);
    endtask

    // Called right after the opcode was accepted with i_tx_ready high.
    task automatic expect_result(input logic [5:0] opc, input logic [7:0] exp);
        check("exec_tx_valid", 32'(o_tx_valid), 32'd0);
        check("exec_rx_ready", 32'(o_rx_ready), 32'd0);
        check("exec_opcode", 32'(o_alu_opcode), 32'(opc));
        @(negedge clk);
        check("send_tx_valid", 32'(o_tx_valid), 32'd1);
        check("send_tx_data", 32'(o_tx_data), 32'(exp));
        @(negedge clk);
        check("done_tx_valid", 32'(o_tx_valid), 32'd0);
        check("done_rx_ready", 32'(o_rx_ready), 32'd1);
        $display("[TB] command op 0x%02h result expected 0x%02h", opc, exp);
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
        i_tx_ready = 1'b1;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        expect_result(op[5:0], exp);
    endtask

    task automatic check_reset_values(input string phase);
        check({phase, "_op_a"}, 32'(o_alu_op_a), 32'd0);
        check({phase, "_op_b"}, 32'(o_alu_op_b), 32'd0);
        check({phase, "_opcode"}, 32'(o_alu_opcode), 32'd0);
        check({phase, "_tx_data"}, 32'(o_tx_data), 32'd0);
        check({phase, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
        check({phase, "_rx_ready"}, 32'(o_rx_ready), 32'd1);
        check({phase, "_err"}, 32'(o_err_opcode), 32'd0);
        check({phase, "_timeout"}, 32'(o_timeout), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        i_reset_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] reset released");
    endtask

    initial begin
        // Reset state
        #1 i_reset_n = 1'b0;
        #2 check_reset_values("reset");
        release_reset();
        check_reset_values("post_reset");

        // ADD back-to-back, result two edges after opcode acceptance
        run_cmd(8'h05, 8'h03, 8'h20, 8'h08);
        check("add_op_a", 32'(o_alu_op_a), 32'h05);
        check("add_op_b", 32'(o_alu_op_b), 32'h03);

        // SUB wraps negative, SRA is arithmetic by B
        run_cmd(8'h03, 8'h05, 8'h22, 8'hFE);
        run_cmd(8'h80, 8'h01, 8'h03, 8'hC0);

        // Unsupported opcodes: 0x3F (bad field), 0x60 (upper bits set)
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h3F);
        check("err3f_pulse", 32'(o_err_opcode), 32'd1);
        check("err3f_tx_valid", 32'(o_tx_valid), 32'd0);
        check("err3f_rx_ready", 32'(o_rx_ready), 32'd1);
        check("err3f_opcode", 32'(o_alu_opcode), 32'h03);
        @(negedge clk);
        check("err3f_pulse_end", 32'(o_err_opcode), 32'd0);
        check("err3f_no_tx", 32'(o_tx_valid), 32'd0);
        send_byte(8'h33);
        check("err_next_is_a", 32'(o_alu_op_a), 32'h33);
        send_byte(8'h44);
        send_byte(8'h60);
        check("err60_pulse", 32'(o_err_opcode), 32'd1);
        check("err60_opcode", 32'(o_alu_opcode), 32'h03);
        @(negedge clk);
        check("err60_pulse_end", 32'(o_err_opcode), 32'd0);
        check("err60_no_tx", 32'(o_tx_valid), 32'd0);

        // Timeout after 16 idle cycles in WAIT_B
        send_byte(8'h10);
        repeat (15) @(negedge clk);
        check("to_not_yet", 32'(o_timeout), 32'd0);
        @(negedge clk);
        check("to_pulse", 32'(o_timeout), 32'd1);
        check("to_rx_ready", 32'(o_rx_ready), 32'd1);
        check("to_stale_a", 32'(o_alu_op_a), 32'h10);
        @(negedge clk);
        check("to_pulse_end", 32'(o_timeout), 32'd0);
        i_tx_ready = 1'b1;
        send_byte(8'hF0);
        check("to_next_is_a", 32'(o_alu_op_a), 32'hF0);
        send_byte(8'h3C);
        send_byte(8'h24);
        expect_result(6'h24, 8'h30);

        // Byte arriving on the expiry edge is accepted
        send_byte(8'h11);
        repeat (15) @(negedge clk);
        send_byte(8'h22);
        check("edge_no_timeout", 32'(o_timeout), 32'd0);
        check("edge_op_b", 32'(o_alu_op_b), 32'h22);
        send_byte(8'h26);
        expect_result(6'h26, 8'h33);

        // Backpressure in SEND
        i_tx_ready = 1'b0;
        send_byte(8'h07);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        i_rx_data  = 8'hAA;
        i_rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_tx_valid", 32'(o_tx_valid), 32'd1);
            check("bp_tx_data", 32'(o_tx_data), 32'h03);
            check("bp_rx_ready", 32'(o_rx_ready), 32'd0);
            @(negedge clk);
        end
        check("bp_not_consumed", 32'(o_alu_op_a), 32'h07);
        i_tx_ready = 1'b1;
        @(negedge clk);
        check("bp_done_tx_valid", 32'(o_tx_valid), 32'd0);
        check("bp_done_rx_ready", 32'(o_rx_ready), 32'd1);
        check("bp_done_op_a", 32'(o_alu_op_a), 32'h07);
        @(negedge clk);
        i_rx_valid = 1'b0;
        check("bp_held_byte_taken", 32'(o_alu_op_a), 32'hAA);
        send_byte(8'h01);
        send_byte(8'h27);
        expect_result(6'h27, 8'h54);

        // Reset mid-command (after B)
        send_byte(8'h44);
        send_byte(8'h55);
        #2 i_reset_n = 1'b0;
        #1 check_reset_values("rst_mid");
        release_reset();
        check("rst_mid_idle_a", 32'(o_alu_op_a), 32'd0);

        // Reset during SEND
        i_tx_ready = 1'b0;
        send_byte(8'h0F);
        send_byte(8'h01);
        send_byte(8'h20);
        @(negedge clk);
        check("rst_send_valid_before", 32'(o_tx_valid), 32'd1);
        check("rst_send_data_before", 32'(o_tx_data), 32'h10);
        #2 i_reset_n = 1'b0;
        #1 check_reset_values("rst_send");
        i_tx_ready = 1'b1;
        release_reset();
        check("rst_send_no_delivery", 32'(o_tx_valid), 32'd0);
        run_cmd(8'h02, 8'h02, 8'h25, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed still running expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Byte-stream command sequencer for the shared ALU. It collects operand A, operand B and opcode as three consecutive bytes on a valid/ready input stream (UART RX side), holds them on the ALU inputs for one execute cycle, and returns the result byte on a valid/ready output stream (UART TX side). It sits between the serial front end and the combinational ALU, replacing direct switch/button loading when the board runs in remote mode.

## Interface
- NB_DATA, 8, operand/result/stream byte width
- NB_OPCODE, 6, ALU opcode width (≤ NB_DATA)
- TIMEOUT, 100000, max idle cycles allowed between bytes of one command
- i_clock  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_rx_data  in  NB_DATA  incoming command byte
- i_rx_valid  in  1  i_rx_data valid
- o_rx_ready  out  1  sequencer accepts a byte this cycle
- o_tx_data  out  NB_DATA  result byte
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  sink accepts result this cycle
- o_alu_op_a  out  NB_DATA  registered operand A to ALU (signed)
- o_alu_op_b  out  NB_DATA  registered operand B to ALU (signed)
- o_alu_opcode  out  NB_OPCODE  registered opcode to ALU
- i_alu_result  in  NB_DATA  combinational ALU result
- o_err_opcode  out  1  one-cycle pulse: unsupported opcode byte
- o_timeout  out  1  one-cycle pulse: partial command discarded

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- o_rx_ready = 1 only in WAIT_A/WAIT_B/WAIT_OP. A byte is accepted on an edge with i_rx_valid & o_rx_ready.
- WAIT_A: accept → o_alu_op_a <= byte, go WAIT_B.
- WAIT_B: accept → o_alu_op_b <= byte, go WAIT_OP.
- WAIT_OP: accept → check byte. Valid opcodes (low NB_OPCODE bits, upper byte bits must be 0): ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02. Valid → o_alu_opcode <= byte[NB_OPCODE-1:0], go EXEC. Invalid → o_alu_opcode unchanged, pulse o_err_opcode, go WAIT_A.
- EXEC: one cycle; ALU inputs stable; at end o_tx_data <= i_alu_result, go SEND.
- SEND: o_tx_valid = 1, o_tx_data held stable until i_tx_ready; on handshake go WAIT_A. No timeout in SEND.
- Timeout counter (width $clog2(TIMEOUT+1)): cleared on every accepted byte and whenever not in WAIT_B/WAIT_OP; increments each cycle in WAIT_B/WAIT_OP without acceptance. When it reaches TIMEOUT: go WAIT_A, pulse o_timeout; operand registers keep stale values.
- Byte accepted on the same edge the counter would expire: acceptance wins, no timeout.
- Operand registers retain values across commands; only overwritten by accepted bytes.
- Result is raw ALU output, no width extension or saturation.

## Timing
- Reset (async, i_reset_n = 0): state WAIT_A; o_alu_op_a/b, o_alu_opcode, o_tx_data = 0; o_tx_valid, o_err_opcode, o_timeout = 0; counter = 0; o_rx_ready = 1.
- Reset mid-command or mid-SEND: immediate abandon, result never delivered; deassertion synchronized internally so first active edge is clean.
- Opcode accepted at edge k → EXEC in cycle k..k+1 → o_tx_valid high after edge k+1 → earliest handshake at edge k+2 → o_rx_ready high after edge k+2.
- Minimum command period: 5 cycles (3 bytes + EXEC + SEND).
- o_err_opcode / o_timeout: high exactly one cycle, after the edge of the event.
- o_rx_ready = 0 in EXEC and SEND regardless of i_rx_valid; upstream must hold byte.

## Test plan
- A=0x05, B=0x03, opcode 0x20 back-to-back, i_tx_ready=1 -> o_tx_data=0x08, o_tx_valid high one cycle, exactly 2 edges after opcode acceptance.
- A=0x03, B=0x05, opcode 0x22 -> o_tx_data=0xFE; then A=0x80, B=0x01, opcode 0x03 (SRA by B) -> 0xC0.
- Opcode bytes 0x3F and 0x60 -> o_err_opcode one-cycle pulse each, no o_tx_valid, state WAIT_A, o_alu_opcode unchanged.
- TIMEOUT=16: A=0x10, idle 16 cycles -> o_timeout pulse, back to WAIT_A; then 0xF0, 0x3C, 0x24 -> 0x30. Byte arriving on expiry cycle -> accepted, no pulse.
- i_tx_ready low 10 cycles in SEND -> o_tx_valid and o_tx_data stable, o_rx_ready=0, input bytes not consumed.
- Assert i_reset_n=0 after B accepted and during SEND -> all outputs to reset values immediately; next command 0x02, 0x02, 0x25 -> 0x02.
